// File: rtl/watch_pkg.sv
// Shared calendar constants, field widths and date helper functions.
// Latency: none, pure declarations and combinational functions.
// Backpressure: not applicable.
package watch_pkg;

   localparam int FIELD_W = 8;
   localparam int WDAY_W  = 3;

   localparam logic [FIELD_W-1:0] JAN = 8'd1;
   localparam logic [FIELD_W-1:0] FEB = 8'd2;
   localparam logic [FIELD_W-1:0] MAR = 8'd3;
   localparam logic [FIELD_W-1:0] APR = 8'd4;
   localparam logic [FIELD_W-1:0] MAY = 8'd5;
   localparam logic [FIELD_W-1:0] JUN = 8'd6;
   localparam logic [FIELD_W-1:0] JUL = 8'd7;
   localparam logic [FIELD_W-1:0] AUG = 8'd8;
   localparam logic [FIELD_W-1:0] SEP = 8'd9;
   localparam logic [FIELD_W-1:0] OCT = 8'd10;
   localparam logic [FIELD_W-1:0] NOV = 8'd11;
   localparam logic [FIELD_W-1:0] DEC = 8'd12;

   localparam logic [WDAY_W-1:0] SUN = 3'd0;
   localparam logic [WDAY_W-1:0] MON = 3'd1;
   localparam logic [WDAY_W-1:0] TUE = 3'd2;
   localparam logic [WDAY_W-1:0] WED = 3'd3;
   localparam logic [WDAY_W-1:0] THU = 3'd4;
   localparam logic [WDAY_W-1:0] FRI = 3'd5;
   localparam logic [WDAY_W-1:0] SAT = 3'd6;

   // Time-of-day bundle used for the tick successor computation.
   typedef struct packed {
      logic [FIELD_W-1:0] hour;
      logic [FIELD_W-1:0] minute;
      logic [FIELD_W-1:0] second;
   } hms_t;

   // Gregorian rule on the absolute year base + offset.
   function automatic logic is_leap(input int unsigned year, input int unsigned base);
      int unsigned y;
      y = base + year;
      return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
   endfunction

   // Returns 0 for an out-of-range month so callers can reject it.
   function automatic logic [FIELD_W-1:0] days_in_month(input logic [FIELD_W-1:0] month,
                                                        input logic leap);
      logic [FIELD_W-1:0] d;
      case (month)
         FEB:                               d = leap ? 8'd29 : 8'd28;
         APR, JUN, SEP, NOV:                d = 8'd30;
         JAN, MAR, MAY, JUL, AUG, OCT, DEC: d = 8'd31;
         default:                           d = 8'd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/watch_days_in_month.sv
// Month length and leap flag for a given (month, year offset).
// Latency: combinational.
// Backpressure: not applicable.
module watch_days_in_month
   import watch_pkg::*;
#(
   parameter int unsigned YEAR_W    = 8,
   parameter int unsigned YEAR_BASE = 2000,
   parameter bit          LEAP_EN   = 1'b1
) (
   input  logic [FIELD_W-1:0] month,
   input  logic [YEAR_W-1:0]  year,
   output logic [FIELD_W-1:0] maxday,
   output logic               leap
);

   // Leap flag is suppressed entirely when the leap rule is disabled.
   always_comb begin
      leap   = LEAP_EN && is_leap(32'(year), YEAR_BASE);
      maxday = days_in_month(month, leap);
   end

endmodule

// File: rtl/watch_calendar_gen.sv
// Calendar/time-of-day counter with validated load, weekday, 12h view and alarm.
// Latency: 1 cycle from clk1sec/set_time to updated registers and pulses.
// Backpressure: none; set_time wins over a same-cycle clk1sec, which is dropped.
module watch_calendar_gen
   import watch_pkg::*;
#(
   parameter int unsigned       YEAR_W    = 8,
   parameter int unsigned       YEAR_BASE = 2000,
   parameter logic [WDAY_W-1:0] WDAY_RST  = SAT,
   parameter bit                LEAP_EN   = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk1sec,
   input  logic                set_time,
   input  logic [YEAR_W+39:0]  bin_time,
   input  logic [WDAY_W-1:0]   set_wday,
   input  logic                alarm_en,
   input  logic [15:0]         alarm_time,
   output logic [YEAR_W-1:0]   year,
   output logic [FIELD_W-1:0]  month,
   output logic [FIELD_W-1:0]  day,
   output logic [FIELD_W-1:0]  hour,
   output logic [FIELD_W-1:0]  minute,
   output logic [FIELD_W-1:0]  second,
   output logic [WDAY_W-1:0]   wday,
   output logic                leap,
   output logic [FIELD_W-1:0]  hour12,
   output logic                pm,
   output logic                day_end,
   output logic                alarm,
   output logic                set_err
);

   // Load fields unpacked from the flat load bus.
   logic [YEAR_W-1:0]  ld_year;
   logic [FIELD_W-1:0] ld_month, ld_day, ld_hour, ld_minute, ld_second;
   logic [FIELD_W-1:0] ld_maxday;
   logic               ld_leap;
   logic               ld_ok;

   assign ld_year   = bin_time[YEAR_W+39:40];
   assign ld_month  = bin_time[39:32];
   assign ld_day    = bin_time[31:24];
   assign ld_hour   = bin_time[23:16];
   assign ld_minute = bin_time[15:8];
   assign ld_second = bin_time[7:0];

   logic [FIELD_W-1:0] cur_maxday;

   // Running date: month length for the rollover and the exported leap flag.
   watch_days_in_month #(
      .YEAR_W    (YEAR_W),
      .YEAR_BASE (YEAR_BASE),
      .LEAP_EN   (LEAP_EN)
   ) u_dim_cur (
      .month  (month),
      .year   (year),
      .maxday (cur_maxday),
      .leap   (leap)
   );

   // Load candidate: the day is validated against its own month and year.
   watch_days_in_month #(
      .YEAR_W    (YEAR_W),
      .YEAR_BASE (YEAR_BASE),
      .LEAP_EN   (LEAP_EN)
   ) u_dim_ld (
      .month  (ld_month),
      .year   (ld_year),
      .maxday (ld_maxday),
      .leap   (ld_leap)
   );

   // ld_maxday is 0 for an invalid month, so the day range check also covers month.
   always_comb begin
      ld_ok = (ld_maxday != 8'd0) && (ld_day >= 8'd1) && (ld_day <= ld_maxday) &&
              (ld_hour < 8'd24) && (ld_minute < 8'd60) && (ld_second < 8'd60) &&
              (set_wday <= SAT);
   end

   // Successor state for one tick, cascading carries from seconds to years.
   hms_t               nxt_hms;
   logic [FIELD_W-1:0] nxt_day, nxt_month;
   logic [YEAR_W-1:0]  nxt_year;
   logic [WDAY_W-1:0]  nxt_wday;
   logic               nxt_day_end;
   logic               alarm_hit;

   // Tick successor cascade.
   always_comb begin
      nxt_hms.hour   = hour;
      nxt_hms.minute = minute;
      nxt_hms.second = second;
      nxt_day        = day;
      nxt_month      = month;
      nxt_year       = year;
      nxt_wday       = wday;
      nxt_day_end    = 1'b0;
      if (second < 8'd59) begin
         nxt_hms.second = second + 8'd1;
      end else begin
         nxt_hms.second = 8'd0;
         if (minute < 8'd59) begin
            nxt_hms.minute = minute + 8'd1;
         end else begin
            nxt_hms.minute = 8'd0;
            if (hour < 8'd23) begin
               nxt_hms.hour = hour + 8'd1;
            end else begin
               nxt_hms.hour = 8'd0;
               nxt_wday     = (wday == SAT) ? SUN : wday + 3'd1;
               nxt_day_end  = 1'b1;
               if (day < cur_maxday) begin
                  nxt_day = day + 8'd1;
               end else begin
                  nxt_day = 8'd1;
                  if (month < DEC) begin
                     nxt_month = month + 8'd1;
                  end else begin
                     nxt_month = JAN;
                     nxt_year  = year + YEAR_W'(1);
                  end
               end
            end
         end
      end
   end

   // Alarm fires only on a tick landing exactly on HH:MM:00.
   always_comb begin
      alarm_hit = alarm_en &&
                  (nxt_hms.hour   == alarm_time[15:8]) &&
                  (nxt_hms.minute == alarm_time[7:0]) &&
                  (nxt_hms.second == 8'd0);
   end

   // Calendar state and one-cycle pulses: reset > load > tick.
   always_ff @(posedge clk) begin
      day_end <= 1'b0;
      alarm   <= 1'b0;
      set_err <= 1'b0;
      if (!rst) begin
         year   <= '0;
         month  <= JAN;
         day    <= 8'd1;
         hour   <= 8'd0;
         minute <= 8'd0;
         second <= 8'd0;
         wday   <= WDAY_RST;
      end else if (set_time) begin
         if (ld_ok) begin
            year   <= ld_year;
            month  <= ld_month;
            day    <= ld_day;
            hour   <= ld_hour;
            minute <= ld_minute;
            second <= ld_second;
            wday   <= set_wday;
         end else begin
            set_err <= 1'b1;
         end
      end else if (clk1sec) begin
         year    <= nxt_year;
         month   <= nxt_month;
         day     <= nxt_day;
         hour    <= nxt_hms.hour;
         minute  <= nxt_hms.minute;
         second  <= nxt_hms.second;
         wday    <= nxt_wday;
         day_end <= nxt_day_end;
         alarm   <= alarm_hit;
      end
   end

   // 12-hour display view.
   always_comb begin
      pm = (hour >= 8'd12);
      if (hour == 8'd0 || hour == 8'd12) hour12 = 8'd12;
      else if (hour > 8'd12)             hour12 = hour - 8'd12;
      else                               hour12 = hour;
   end

endmodule

// File: tb/tb_watch_calendar_gen.sv
// Directed self-checking bench for watch_calendar_gen.
// Latency: checks sampled 1 time unit after each clock edge.
// Backpressure: not applicable.
module tb_watch_calendar_gen;

   logic        clk;
   logic        rst;
   logic        clk1sec;
   logic        set_time;
   logic [47:0] bin_time;
   logic [2:0]  set_wday;
   logic        alarm_en;
   logic [15:0] alarm_time;
   logic [7:0]  year, month, day, hour, minute, second, hour12;
   logic [2:0]  wday;
   logic        leap, pm, day_end, alarm, set_err;

   int checks = 0;
   int errors = 0;

   watch_calendar_gen dut (
      .clk        (clk),
      .rst        (rst),
      .clk1sec    (clk1sec),
      .set_time   (set_time),
      .bin_time   (bin_time),
      .set_wday   (set_wday),
      .alarm_en   (alarm_en),
      .alarm_time (alarm_time),
      .year       (year),
      .month      (month),
      .day        (day),
      .hour       (hour),
      .minute     (minute),
      .second     (second),
      .wday       (wday),
      .leap       (leap),
      .hour12     (hour12),
      .pm         (pm),
      .day_end    (day_end),
      .alarm      (alarm),
      .set_err    (set_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int y, input int mo, input int d,
                            input int h, input int mi, input int s, input int w);
      chk({tag, ".year"},   32'(year),   32'(y));
      chk({tag, ".month"},  32'(month),  32'(mo));
      chk({tag, ".day"},    32'(day),    32'(d));
      chk({tag, ".hour"},   32'(hour),   32'(h));
      chk({tag, ".minute"}, 32'(minute), 32'(mi));
      chk({tag, ".second"}, 32'(second), 32'(s));
      chk({tag, ".wday"},   32'(wday),   32'(w));
   endtask

   // Advance one clock and sample shortly after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int y, input int mo, input int d, input int h,
                       input int mi, input int s, input int w, input logic with_tick);
      bin_time = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
      set_wday = 3'(w);
      set_time = 1'b1;
      clk1sec  = with_tick;
      cyc();
      set_time = 1'b0;
      clk1sec  = 1'b0;
   endtask

   task automatic tick();
      clk1sec = 1'b1;
      cyc();
      clk1sec = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      clk1sec    = 1'b0;
      set_time   = 1'b0;
      bin_time   = '0;
      set_wday   = 3'd0;
      alarm_en   = 1'b0;
      alarm_time = 16'h0000;
      #1;
      cyc();
      cyc();
      rst = 1'b1;

      // Reset state
      chk_state("reset", 0, 1, 1, 0, 0, 0, 6);
      chk("reset.leap",    32'(leap),    32'd1);
      chk("reset.hour12",  32'(hour12),  32'd12);
      chk("reset.pm",      32'(pm),      32'd0);
      chk("reset.day_end", 32'(day_end), 32'd0);
      chk("reset.alarm",   32'(alarm),   32'd0);
      chk("reset.set_err", 32'(set_err), 32'd0);

      // Idle cycles change nothing; a tick advances the second
      cyc();
      cyc();
      chk("idle.second", 32'(second), 32'd0);
      tick();
      chk("tick1.second", 32'(second), 32'd1);
      tick();
      chk("tick2.second", 32'(second), 32'd2);

      // Leap day in 2024
      load(24, 2, 28, 23, 59, 59, 3, 1'b0);
      chk_state("ld_leap", 24, 2, 28, 23, 59, 59, 3);
      chk("ld_leap.set_err", 32'(set_err), 32'd0);
      tick();
      chk_state("leapday", 24, 2, 29, 0, 0, 0, 4);
      chk("leapday.day_end", 32'(day_end), 32'd1);
      chk("leapday.leap",    32'(leap),    32'd1);
      cyc();
      chk("leapday.day_end_clr", 32'(day_end), 32'd0);

      // 2100 is not a leap year
      load(100, 2, 28, 23, 59, 59, 0, 1'b0);
      chk("y2100.leap", 32'(leap), 32'd0);
      tick();
      chk_state("y2100", 100, 3, 1, 0, 0, 0, 1);

      // 2000 is a leap year
      load(0, 2, 28, 23, 59, 59, 1, 1'b0);
      tick();
      chk_state("y2000", 0, 2, 29, 0, 0, 0, 2);

      // 30-day month rollover, no alarm expected while disabled
      load(24, 4, 30, 23, 59, 59, 2, 1'b0);
      tick();
      chk_state("apr30", 24, 5, 1, 0, 0, 0, 3);

      // Year wrap 255 -> 0, Saturday wraps to Sunday
      load(255, 12, 31, 23, 59, 59, 6, 1'b0);
      tick();
      chk_state("ywrap", 0, 1, 1, 0, 0, 0, 0);
      chk("ywrap.day_end", 32'(day_end), 32'd1);

      // Rejected loads leave state untouched and pulse set_err for one cycle
      load(23, 2, 29, 10, 0, 0, 3, 1'b0);
      chk("bad_feb29.set_err", 32'(set_err), 32'd1);
      chk_state("bad_feb29", 0, 1, 1, 0, 0, 0, 0);
      cyc();
      chk("bad_feb29.set_err_clr", 32'(set_err), 32'd0);
      load(23, 3, 1, 24, 0, 0, 3, 1'b0);
      chk("bad_hour.set_err", 32'(set_err), 32'd1);
      chk("bad_hour.hour",    32'(hour),    32'd0);
      load(23, 3, 1, 10, 0, 0, 7, 1'b0);
      chk("bad_wday.set_err", 32'(set_err), 32'd1);
      chk("bad_wday.wday",    32'(wday),    32'd0);
      load(23, 13, 1, 10, 0, 0, 1, 1'b0);
      chk("bad_month.set_err", 32'(set_err), 32'd1);
      chk("bad_month.month",   32'(month),   32'd1);

      // Load and tick on the same edge: load wins, no increment
      load(10, 5, 15, 8, 30, 0, 2, 1'b1);
      chk_state("ld_tick", 10, 5, 15, 8, 30, 0, 2);
      chk("ld_tick.set_err", 32'(set_err), 32'd0);
      chk("ld_tick.hour12",  32'(hour12),  32'd8);
      chk("ld_tick.pm",      32'(pm),      32'd0);

      // Alarm: a load onto the alarm time does not fire it
      alarm_en   = 1'b1;
      alarm_time = {8'd13, 8'd5};
      load(10, 5, 15, 13, 5, 0, 2, 1'b0);
      chk("alarm_ld.alarm", 32'(alarm), 32'd0);
      // Tick onto the alarm minute fires exactly once
      load(10, 5, 15, 13, 4, 59, 2, 1'b0);
      tick();
      chk("alarm_hit.alarm",  32'(alarm),  32'd1);
      chk("alarm_hit.minute", 32'(minute), 32'd5);
      chk("alarm_hit.hour12", 32'(hour12), 32'd1);
      chk("alarm_hit.pm",     32'(pm),     32'd1);
      cyc();
      chk("alarm_hit.alarm_clr", 32'(alarm), 32'd0);
      tick();
      chk("alarm_next.alarm", 32'(alarm), 32'd0);
      // Same tick with alarm disabled
      alarm_en = 1'b0;
      load(10, 5, 15, 13, 4, 59, 2, 1'b0);
      tick();
      chk("alarm_dis.alarm", 32'(alarm), 32'd0);

      // Noon in the 12-hour view
      load(10, 5, 15, 12, 0, 0, 2, 1'b0);
      chk("noon.hour12", 32'(hour12), 32'd12);
      chk("noon.pm",     32'(pm),     32'd1);

      // Reset mid-run with a simultaneous tick
      load(10, 5, 15, 23, 59, 59, 2, 1'b0);
      rst     = 1'b0;
      clk1sec = 1'b1;
      cyc();
      rst     = 1'b1;
      clk1sec = 1'b0;
      chk_state("rst_mid", 0, 1, 1, 0, 0, 0, 6);
      chk("rst_mid.day_end", 32'(day_end), 32'd0);
      chk("rst_mid.hour12",  32'(hour12),  32'd12);
      chk("rst_mid.pm",      32'(pm),      32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
